// File: rtl/channel_pkg.sv
// Shared definitions for the channel width converters (serializer today,
// deserializer later): serializer state encoding and width helpers.
package channel_pkg;

  typedef enum logic [0:0] {
    EMPTY   = 1'b0,
    SENDING = 1'b1
  } ser_state_e;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  // Counter width that never collapses to zero bits, even for a single chunk.
  function automatic int clog2_min1(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/channel_chunk_mux.sv
// Selects chunk idx of a held word; bits above NIn-1 in the last chunk read as zero.
module channel_chunk_mux
  import channel_pkg::*;
#(
  parameter int NIn  = 32,
  parameter int NOut = 8
) (
  input  logic [NIn-1:0]                                word,
  input  logic [clog2_min1(ceil_div(NIn, NOut))-1:0]    idx,
  output logic [NOut-1:0]                               chunk
);

  localparam int K  = ceil_div(NIn, NOut);
  localparam int IW = clog2_min1(K);

  logic [K*NOut-1:0] padded_s;

  // zero-extend the word to a whole number of chunks, then pick one
  always_comb begin
    padded_s = '0;
    padded_s[NIn-1:0] = word;
    chunk = '0;
    for (int i = 0; i < K; i++) begin
      chunk = (idx == IW'(i)) ? padded_s[i*NOut +: NOut] : chunk;
    end
  end

endmodule

// File: rtl/channel_serializer_chk.sv
// Simulation checks for channel_serializer: legal widths and a frozen chunk while stalled.
module channel_serializer_chk #(
  parameter int NIn  = 32,
  parameter int NOut = 8
) (
  input logic            clk,
  input logic            reset,
  input logic            out_v,
  input logic            out_a,
  input logic [NOut-1:0] out_d
);

  logic            stalled_r;
  logic [NOut-1:0] prev_d_r;

  // remember whether the previous cycle offered a chunk that was not taken
  always_ff @(posedge clk) begin
    if (reset) begin
      stalled_r <= 1'b0;
      prev_d_r  <= '0;
    end else begin
      stalled_r <= out_v && !out_a;
      prev_d_r  <= out_d;
    end
  end

  // a stalled chunk must not change; widths must be legal
  always_ff @(posedge clk) begin
    assert (NIn >= NOut && NOut >= 1)
      else $error("channel_serializer: illegal widths NIn=%0d NOut=%0d", NIn, NOut);
    if (!reset && stalled_r) begin
      assert (out_d == prev_d_r)
        else $error("channel_serializer: out_d changed while stalled (%h -> %h)", prev_d_r, out_d);
    end
  end

endmodule

// File: rtl/channel_serializer.sv
// Width-down converter: one NIn-bit word in, K NOut-bit chunks out (LS chunk first),
// full rate with the next word accepted as the final chunk leaves.
module channel_serializer
  import channel_pkg::*;
#(
  parameter int NIn  = 32,
  parameter int NOut = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NIn-1:0]  in_d,
  input  logic            in_v,
  output logic            in_a,
  output logic [NOut-1:0] out_d,
  output logic            out_v,
  input  logic            out_a,
  output logic            out_last
);

  localparam int K  = ceil_div(NIn, NOut);
  localparam int IW = clog2_min1(K);
  localparam logic [IW-1:0] LAST_IDX = IW'(K - 1);

  ser_state_e      state_r, next_state_s;
  logic [NIn-1:0]  word_r, next_word_s;
  logic [IW-1:0]   idx_r, next_idx_s;
  logic [NOut-1:0] chunk_s;
  logic            at_last_s;

  assign at_last_s = (idx_r == LAST_IDX);

  channel_chunk_mux #(.NIn(NIn), .NOut(NOut)) u_mux (
    .word  (word_r),
    .idx   (idx_r),
    .chunk (chunk_s)
  );

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= EMPTY;
      idx_r   <= '0;
      word_r  <= '0;
    end else begin
      state_r <= next_state_s;
      idx_r   <= next_idx_s;
      word_r  <= next_word_s;
    end
  end

  // next state: load on an accepted word, step through chunks, reload on the last one
  always_comb begin
    next_state_s = state_r;
    next_idx_s   = idx_r;
    next_word_s  = word_r;
    case (state_r)
      EMPTY: begin
        if (in_v) begin
          next_word_s  = in_d;
          next_idx_s   = '0;
          next_state_s = SENDING;
        end else begin
          next_state_s = EMPTY;
        end
      end
      SENDING: begin
        if (!out_a) begin
          next_state_s = SENDING;
        end else if (!at_last_s) begin
          next_idx_s = idx_r + IW'(1);
        end else if (in_v) begin
          next_word_s = in_d;
          next_idx_s  = '0;
        end else begin
          next_idx_s   = '0;
          next_state_s = EMPTY;
        end
      end
      default: begin
        next_idx_s   = '0;
        next_state_s = EMPTY;
      end
    endcase
  end

  // outputs: reset gates both valids immediately; out_v never looks at out_a
  always_comb begin
    out_v    = (state_r == SENDING) && !reset;
    out_last = out_v && at_last_s;
    out_d    = out_v ? chunk_s : '0;
    in_a     = !reset && ((state_r == EMPTY) || (out_last && out_a));
  end

  channel_serializer_chk #(.NIn(NIn), .NOut(NOut)) u_chk (
    .clk   (clk),
    .reset (reset),
    .out_v (out_v),
    .out_a (out_a),
    .out_d (out_d)
  );

endmodule

// File: tb/tb_channel_serializer.sv
// Bench for channel_serializer: three widths (32/8, 20/8, 8/8) against a chunk-queue model.
module tb_channel_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] din;
  logic        vin;
  logic        aout;
  int          sel;

  logic [19:0] din1;
  logic [7:0]  din2;
  logic        ia0, ia1, ia2, ov0, ov1, ov2, ol0, ol1, ol2;
  logic [7:0]  od0, od1, od2;
  logic        obs_v, obs_last, obs_ia;
  logic [7:0]  obs_d;

  assign din1 = din[19:0];
  assign din2 = din[7:0];

  channel_serializer #(.NIn(32), .NOut(8)) u0 (
    .clk(clk), .reset(rst), .in_d(din), .in_v(vin && sel == 0), .in_a(ia0),
    .out_d(od0), .out_v(ov0), .out_a(aout && sel == 0), .out_last(ol0));
  channel_serializer #(.NIn(20), .NOut(8)) u1 (
    .clk(clk), .reset(rst), .in_d(din1), .in_v(vin && sel == 1), .in_a(ia1),
    .out_d(od1), .out_v(ov1), .out_a(aout && sel == 1), .out_last(ol1));
  channel_serializer #(.NIn(8), .NOut(8)) u2 (
    .clk(clk), .reset(rst), .in_d(din2), .in_v(vin && sel == 2), .in_a(ia2),
    .out_d(od2), .out_v(ov2), .out_a(aout && sel == 2), .out_last(ol2));

  always_comb begin
    case (sel)
      0:       begin obs_v = ov0; obs_last = ol0; obs_ia = ia0; obs_d = od0; end
      1:       begin obs_v = ov1; obs_last = ol1; obs_ia = ia1; obs_d = od1; end
      default: begin obs_v = ov2; obs_last = ol2; obs_ia = ia2; obs_d = od2; end
    endcase
  end

  // Model: the chunks still owed downstream, oldest first.
  logic [7:0]  q[$];
  logic [7:0]  got[$];
  logic [31:0] accepted[$];
  int n_assert = 0;
  int n_fail   = 0;
  int n_in_hs  = 0;

  function automatic int nin_of(input int s);
    return (s == 0) ? 32 : (s == 1) ? 20 : 8;
  endfunction

  function automatic logic [31:0] mask_word(input logic [31:0] w, input int nin);
    return (nin < 32) ? (w & ((32'd1 << nin) - 32'd1)) : w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    logic       ev, el, eia, ohs, ihs;
    logic [7:0] ed;
    logic [31:0] w;
    int nin;
    @(negedge clk);
    ev  = !rst && q.size() > 0;
    el  = ev && q.size() == 1;
    eia = !rst && (q.size() == 0 || (q.size() == 1 && aout));
    ed  = 8'h00;
    if (ev) ed = q[0];
    check("out_v", 32'(obs_v), 32'(ev));
    check("out_last", 32'(obs_last), 32'(el));
    check("in_a", 32'(obs_ia), 32'(eia));
    check("out_d", 32'(obs_d), 32'(ed));
    ohs = ev && aout;
    ihs = eia && vin;
    if (obs_v && aout) got.push_back(obs_d);
    if (obs_ia && vin) begin
      n_in_hs++;
      accepted.push_back(din);
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      if (ohs) void'(q.pop_front());
      if (ihs) begin
        nin = nin_of(sel);
        w = mask_word(din, nin);
        for (int i = 0; i < (nin + 7) / 8; i++) q.push_back(8'(w >> (8 * i)));
      end
    end
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Compare the collected output bytes with a constant, least-significant byte first.
  task automatic check_got(input string tag, input int n, input logic [63:0] exp);
    logic [7:0] b;
    check({tag, "_count"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      b = 8'hxx;
      if (i < got.size()) b = got[i];
      check(tag, 32'(b), 32'(exp[8*i +: 8]));
    end
    got.delete();
  endtask

  // Compare the collected output bytes with the chunking of every accepted word.
  task automatic check_stream(input string tag, input int nwords);
    logic [7:0] exp_b[$];
    logic [31:0] w;
    int nin;
    nin = nin_of(sel);
    check({tag, "_words"}, 32'(accepted.size()), 32'(nwords));
    foreach (accepted[j]) begin
      w = mask_word(accepted[j], nin);
      for (int i = 0; i < (nin + 7) / 8; i++) exp_b.push_back(8'(w >> (8 * i)));
    end
    check({tag, "_count"}, 32'(got.size()), 32'(exp_b.size()));
    for (int i = 0; i < exp_b.size() && i < got.size(); i++) check(tag, 32'(got[i]), 32'(exp_b[i]));
    got.delete();
    accepted.delete();
  endtask

  task automatic random_stream(input string tag, input int nwords);
    got.delete();
    accepted.delete();
    for (int c = 0; c < 400 && !(accepted.size() == nwords && q.size() == 0); c++) begin
      aout = ($urandom_range(0, 3) != 0);
      vin  = (accepted.size() < nwords) && ($urandom_range(0, 1) == 1);
      din  = $urandom;
      tick();
    end
    vin = 1'b0;
    check_stream(tag, nwords);
  endtask

  initial begin
    rst = 1'b1; din = 32'h0; vin = 1'b0; aout = 1'b0; sel = 0;
    ticks(2);
    rst = 1'b0;
    tick();

    // single word, always-ready sink
    aout = 1'b1; got.delete();
    din = 32'hDDCCBBAA; vin = 1'b1; tick();
    vin = 1'b0; din = $urandom; ticks(5);
    check_got("t1_chunks", 4, 64'hDDCCBBAA);

    // back-to-back words, no gap
    n_in_hs = 0;
    din = 32'h04030201; vin = 1'b1; tick();
    din = 32'h08070605; ticks(4);
    vin = 1'b0; ticks(5);
    check_got("t2_chunks", 8, 64'h0807060504030201);
    check("t2_in_handshakes", 32'(n_in_hs), 32'd2);

    // 20-bit word with padded top chunk
    sel = 1;
    din = 32'h000ABCDE; vin = 1'b1; tick();
    vin = 1'b0; ticks(4);
    check_got("t3_chunks", 3, 64'h0A_BC_DE);

    // stall on the second chunk while upstream offers junk, then a second word
    sel = 0; aout = 1'b1;
    din = 32'hDDCCBBAA; vin = 1'b1; tick();
    din = 32'h55667788; tick();
    aout = 1'b0;
    for (int i = 0; i < 3; i++) begin
      din = $urandom;
      tick();
    end
    aout = 1'b1; din = 32'h55667788; ticks(3);
    vin = 1'b0; ticks(5);
    check_got("t4_chunks", 8, 64'h55667788DDCCBBAA);

    // reset in the middle of a word
    din = 32'hDDCCBBAA; vin = 1'b1; tick();
    vin = 1'b0; tick();
    rst = 1'b1; ticks(2);
    rst = 1'b0; tick();
    got.delete();
    din = 32'h11223344; vin = 1'b1; tick();
    vin = 1'b0; ticks(5);
    check_got("t5_chunks", 4, 64'h11223344);

    // random words with random backpressure
    sel = 2;
    random_stream("t6_stream", 10);
    sel = 0;
    random_stream("t7_stream", 5);
    sel = 1;
    random_stream("t8_stream", 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/channel_serializer.md
Name: channel_serializer

Overview:
- Width-down converter between a wide Channel and a narrow Channel, e.g. a wide merged word serialized onto a narrow link toward the BD/host interface.
- Accepts one NIn-bit word per handshake and emits it as K = ceil(NIn/NOut) NOut-bit chunks, least-significant chunk first.
- One-word holding register plus chunk counter.
- Sustains full rate: one chunk per cycle, with no bubble between words.

Parameters:
- NIn, 32, input word width; must be >= NOut.
- NOut, 8, output chunk width; must be >= 1.
- K (localparam), ceil(NIn/NOut), number of chunks per word.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- in  Channel  NIn  upstream word channel; d/v driven by upstream, a driven here.
- out  Channel  NOut  downstream chunk channel; d/v driven here, a driven by downstream.
- out_last  output  1  high when the current out.d is chunk K-1 of its word; valid only while out.v=1.

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Handshake: a transfer occurs on a channel in any cycle where v=1 and a=1 at the posedge.
  - v/d are registered or state-derived.
  - a may be combinational from the partner's v.
  - out.v never depends combinationally on out.a.
- State: EMPTY, SENDING. Registers: word[NIn-1:0], idx[$clog2(K) max 1 bits].
- Reset (clk edge with reset=1): state<=EMPTY, idx<=0, word<=0.
  - While reset=1: in.a=0 and out.v=0, gated combinationally.
  - Out of reset: out.v=0, out_last=0, in.a=1.
- out.v = (state==SENDING) & ~reset.
- out.d = word[idx*NOut +: NOut].
  - The last chunk is zero-padded above bit NIn-1.
  - out.d is 0 when out.v=0.
- out_last = out.v & (idx==K-1).
- in.a = ~reset & ((state==EMPTY) | (out_last & out.a)), i.e. a new word is accepted in the same cycle the final chunk leaves.
- Transitions:
  - EMPTY, in.v=1: word<=in.d, idx<=0, go to SENDING. First chunk appears the next cycle; latency is 1 cycle.
  - EMPTY, in.v=0: stay.
  - SENDING, out.a=0: hold. word, idx, out.d and out_last are all stable.
  - SENDING, out.a=1, idx<K-1: idx<=idx+1.
  - SENDING, out.a=1, idx==K-1, in.v=1: word<=in.d, idx<=0, stay SENDING (back-to-back, no gap).
  - SENDING, out.a=1, idx==K-1, in.v=0: go to EMPTY, idx<=0.
- Throughput: exactly K cycles per word when out.a is held at 1 and in.v is held at 1.
- K==1: the block degenerates to a one-deep registered pipeline stage, one word per cycle. out_last is always high while out.v=1.
- Upstream data is ignored when in.a=0. in.d is sampled only on the in handshake.
- Reset asserted mid-word: the held word is discarded with no partial-word completion. out.v is 0 from the reset cycle onward.
- Simulation assertions:
  - NIn >= NOut >= 1 at elaboration.
  - out.d stable while out.v & ~out.a.

Decomposition:
- Shared package channel_pkg:
  - function ceil_div(a,b).
  - function clog2_min1(x), which returns at least 1.
  - Both are reused by future width converters (a deserializer is the mirror block).
- One natural sub-module: channel_chunk_mux (combinational select of chunk idx with zero padding, parameterized NIn/NOut). Everything else lives in channel_serializer.

Test Plan:
1. NIn=32, NOut=8, out.a tied 1; send 0xDDCCBBAA -> out.d = AA,BB,CC,DD on 4 consecutive cycles starting 1 cycle after the in handshake; out_last only on DD; in.a high in the DD cycle.
2. Back-to-back words 0x04030201 then 0x08070605, in.v held, out.a=1 -> 8 consecutive chunks 01..08 with no idle cycle; exactly 2 in handshakes.
3. NIn=20, NOut=8, word 0xABCDE -> chunks DE, BC, 0A (top nibble zero-padded), out_last on 0A.
4. Random out.a stall (e.g. low for 3 cycles during chunk BB) -> out.d holds BB and idx unchanged; in.a stays 0 until the final chunk handshake; sequence intact.
5. Reset asserted one cycle after chunk AA transfers -> out.v=0 and in.a=0 during reset; after release out.v=0 and in.a=1; next word 0x11223344 emits 44,33,22,11 with no remnants.
6. NIn=NOut=8, stream 10 random words with random out.a -> output sequence equals input sequence; out_last=1 on every transfer.
